// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with 256-bit lines.
// Serves one outstanding LSQ load/store and talks to line-granular memory.
module dcache_responder #(
    parameter int unsigned S_INDEX  = 3,
    parameter int unsigned S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int unsigned S_TAG = 32 - S_INDEX - S_OFFSET;
    localparam int unsigned SETS  = 1 << S_INDEX;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_e;

    state_e             state_q;
    logic [31:2]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               write_q;
    logic               resp_q;
    logic               pmem_read_q;
    logic               pmem_write_q;
    logic [31:0]        pmem_addr_q;

    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [S_TAG-1:0]   tag_q  [SETS];
    logic [255:0]       data_q [SETS];

    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0]   tag;
    logic [7:0]         word_base;
    logic [255:0]       line;
    logic [255:0]       merged_line;
    logic [31:0]        rd_word;
    logic               hit;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^mem_address[1:0];

    always_comb begin
        idx         = addr_q[S_OFFSET +: S_INDEX];
        tag         = addr_q[31 -: S_TAG];
        word_base   = {addr_q[4:2], 5'b00000};
        line        = data_q[idx];
        hit         = valid_q[idx] && (tag_q[idx] == tag);
        rd_word     = line[word_base +: 32];
        merged_line = line;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                merged_line[word_base + 8'(8 * b) +: 8] = wdata_q[8 * b +: 8];
            end
        end
    end

    // Hit response is combinational in COMPARE so the word is returned the same cycle.
    assign mem_resp     = (state_q == COMPARE) && hit;
    assign mem_rdata    = mem_resp ? rd_word : '0;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_addr_q;
    assign pmem_wdata   = pmem_write_q ? line : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            write_q      <= 1'b0;
            resp_q       <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            resp_q <= mem_resp;
            unique case (state_q)
                IDLE: begin
                    // resp_q masks the stale request still held in the cycle after mem_resp.
                    if ((mem_read || mem_write) && !resp_q) begin
                        addr_q  <= mem_address[31:2];
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                        write_q <= !mem_read;
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (write_q) begin
                            dirty_q[idx] <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        pmem_write_q <= 1'b1;
                        pmem_addr_q  <= {tag_q[idx], idx, {S_OFFSET{1'b0}}};
                        state_q      <= WRITEBACK;
                    end else begin
                        pmem_read_q <= 1'b1;
                        pmem_addr_q <= {tag, idx, {S_OFFSET{1'b0}}};
                        state_q     <= FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        pmem_write_q <= 1'b0;
                        pmem_read_q  <= 1'b1;
                        pmem_addr_q  <= {tag, idx, {S_OFFSET{1'b0}}};
                        state_q      <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        pmem_read_q  <= 1'b0;
                        pmem_addr_q  <= '0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= COMPARE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage has no reset; validity alone decides whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == COMPARE && hit && write_q) begin
                data_q[idx] <= merged_line;
            end else if (state_q == FILL && pmem_resp) begin
                data_q[idx] <= pmem_rdata;
                tag_q[idx]  <= tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench: a flat word-memory reference plus a set-level hit/miss model
// predict responses and backing-memory traffic for directed and random requests.
module tb_dcache_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    dcache_responder #(.S_INDEX(3), .S_OFFSET(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    typedef struct {bit is_read; logic [31:0] rdata;} sb_t;
    typedef struct {bit wr; logic [31:0] addr; logic [255:0] data;} pm_t;

    int errors = 0;
    int checks = 0;
    sb_t sb_q[$];
    pm_t pm_exp[$];
    sb_t mon_e;
    logic [255:0] pm_mem [int unsigned];
    logic [31:0]  ref_mem [int unsigned];
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [23:0]  m_tag [8];
    int           pm_delay_fix = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_1044) return 32'hDEAD_BEEF;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [255:0] get_line(input logic [26:0] la);
        logic [255:0] l;
        if (pm_mem.exists(la)) return pm_mem[la];
        for (int w = 0; w < 8; w++) l[32 * w +: 32] = init_word({la, 5'b0} + 32'(4 * w));
        return l;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [255:0] l;
        logic [7:0]   base;
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        l    = get_line(a[31:5]);
        base = {a[4:2], 5'b0};
        return l[base +: 32];
    endfunction

    function automatic logic [255:0] ref_line(input logic [26:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32 * w +: 32] = ref_read({la, 5'b0} + 32'(4 * w));
        return l;
    endfunction

    // Predict the outcome of one request and update the reference views.
    task automatic prepare(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, output bit exp_hit);
        logic [2:0]  s;
        logic [23:0] tg;
        logic [31:0] cur;
        s  = addr[7:5];
        tg = addr[31:8];
        exp_hit = m_valid[s] && (m_tag[s] == tg);
        if (!exp_hit) begin
            if (m_valid[s] && m_dirty[s])
                pm_exp.push_back('{1'b1, {m_tag[s], s, 5'b0}, ref_line({m_tag[s], s})});
            pm_exp.push_back('{1'b0, {tg, s, 5'b0}, 256'b0});
            m_valid[s] = 1'b1;
            m_tag[s]   = tg;
            m_dirty[s] = 1'b0;
        end
        if (rd) begin
            sb_q.push_back('{1'b1, ref_read(addr)});
        end else if (wr) begin
            sb_q.push_back('{1'b0, 32'b0});
            m_dirty[s] = 1'b1;
            cur = ref_read(addr);
            for (int b = 0; b < 4; b++) if (be[b]) cur[8 * b +: 8] = wd[8 * b +: 8];
            ref_mem[addr[31:2]] = cur;
        end
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input bit drop);
        bit h;
        bit got;
        int lat;
        prepare(rd, wr, addr, wd, be, h);
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_wdata = wd; mem_byte_enable = be;
        lat = 0; got = 0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            if (mem_resp) got = 1;
            else if (drop && lat == 3) begin mem_read = 0; mem_write = 0; end
        end
        chk("resp_seen", got, 1);
        if (h) chk("hit_latency", lat, 2);
        else   chk("miss_latency_gt2", lat > 2, 1);
        chk("pmem_ops_done", pm_exp.size(), 0);
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
        @(posedge clk); #1;
    endtask

    // Backing memory: checks each transaction against the prediction, responds after a delay.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            logic [31:0]  a;
            logic [255:0] wd;
            bit           w;
            bit           abort;
            int           d;
            pm_t          e;
            @(negedge clk);
            if (!rst && (pmem_read || pmem_write)) begin
                a = pmem_address; w = pmem_write; wd = pmem_wdata;
                chk("pmem_addr_aligned", a[4:0], 0);
                chk("pmem_expected", pm_exp.size() != 0, 1);
                if (pm_exp.size() != 0) begin
                    e = pm_exp.pop_front();
                    chk("pmem_op_is_write", w, e.wr);
                    chk("pmem_addr", a, e.addr);
                    if (w) chk("pmem_wdata", wd, e.data);
                end
                d = (pm_delay_fix != 0) ? pm_delay_fix : int'($urandom_range(1, 4));
                abort = 0;
                for (int i = 0; i < d && !abort; i++) begin
                    @(posedge clk);
                    if (rst) abort = 1;
                end
                if (!abort) begin
                    #1;
                    if (w) pm_mem[a[31:5]] = wd;
                    else   pmem_rdata = get_line(a[31:5]);
                    pmem_resp = 1'b1;
                    @(posedge clk); #1;
                    pmem_resp = 1'b0;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("pmem_rw_exclusive", pmem_read & pmem_write, 0);
                if (mem_resp) begin
                    chk("resp_expected", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        mon_e = sb_q.pop_front();
                        if (mon_e.is_read) chk("rdata", mem_rdata, mon_e.rdata);
                    end
                end else begin
                    chk("rdata_zero_without_resp", mem_rdata, 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        bit          h;
        bit          got;
        logic [31:0] a;
        int          r;
        rst = 1'b1;
        mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        pm_delay_fix = 3;
        do_req(1, 0, 32'h0000_1044, 32'h0, 4'h0, 0);
        pm_delay_fix = 0;
        do_req(1, 0, 32'h0000_1044, 32'h0, 4'h0, 0);
        do_req(0, 1, 32'h0000_1044, 32'h0000_AB00, 4'b0010, 0);
        chk("merged_word_model", ref_read(32'h0000_1044), 32'hDEAD_ABEF);
        do_req(1, 0, 32'h0000_1044, 32'h0, 4'h0, 0);
        do_req(1, 1, 32'h0000_1044, 32'hFFFF_FFFF, 4'hF, 0);
        do_req(1, 0, 32'h0000_2044, 32'h0, 4'h0, 0);
        do_req(1, 0, 32'h0000_3044, 32'h0, 4'h0, 1);
        do_req(0, 1, 32'h0000_3048, 32'h1234_5678, 4'b0000, 0);
        do_req(1, 0, 32'h0000_1044, 32'h0, 4'h0, 0);

        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 3));
            a = ((r == 0) ? 32'h10 : (r == 1) ? 32'h20 : (r == 2) ? 32'h30 : 32'h41) << 8;
            a = a | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            r = int'($urandom_range(0, 9));
            if (r < 5)      do_req(1, 0, a, 32'h0, 4'h0, 0);
            else if (r < 9) do_req(0, 1, a, $urandom, 4'($urandom_range(0, 15)), 0);
            else            do_req(1, 1, a, $urandom, 4'hF, 0);
        end

        do_req(0, 1, 32'h0000_1044, 32'h1122_3344, 4'hF, 0);
        pm_delay_fix = 30;
        prepare(1, 0, 32'h0000_2044, 32'h0, 4'h0, h);
        mem_read = 1; mem_address = 32'h0000_2044;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (pmem_write) got = 1;
        end
        chk("writeback_started", got, 1);
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete(); pm_exp.delete(); ref_mem.delete();
        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        @(negedge clk);
        chk("midop_rst_pmem_write", pmem_write, 0);
        chk("midop_rst_pmem_read", pmem_read, 0);
        chk("midop_rst_mem_resp", mem_resp, 0);
        pm_delay_fix = 0;
        repeat (3) @(posedge clk);
        #1;
        do_req(1, 0, 32'h0000_1044, 32'h0, 4'h0, 0);
        do_req(1, 0, 32'h0000_1044, 32'h0, 4'h0, 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
